// File: rtl/cdda_sector_feeder_if.sv
// Memory read port and cdda_fifo write handshake of the CDDA sector feeder.
interface cdda_sector_feeder_if #(
  parameter int ADDR_WIDTH = 24
);
  logic                  mem_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [15:0]           mem_data;
  logic                  hdd_cdda_req;
  logic                  hdd_cdda_wr;
  logic [15:0]           hdd_data_out;

  modport master (
    output mem_rd, mem_addr, hdd_cdda_wr, hdd_data_out,
    input  mem_ack, mem_data, hdd_cdda_req
  );

  modport slave (
    input  mem_rd, mem_addr, hdd_cdda_wr, hdd_data_out,
    output mem_ack, mem_data, hdd_cdda_req
  );
endinterface

// File: rtl/cdda_sector_feeder.sv
// Streams whole 2352-byte CDDA sectors from word-addressed memory into cdda_fifo.
// Define CDDA_FEEDER_LOOP_EN to honour `loop` (wrap to start_lba at end_lba).
module cdda_sector_feeder #(
  parameter int ADDR_WIDTH   = 24,
  parameter int SECTOR_WORDS = 1176
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [19:0]           start_lba,
  input  logic [19:0]           end_lba,
  input  logic                  load,
  input  logic                  play,
  input  logic                  loop,
  cdda_sector_feeder_if.master  bus,
  output logic                  playing,
  output logic                  done,
  output logic [19:0]           cur_lba
);
  localparam int IW = $clog2(SECTOR_WORDS);
  localparam logic [IW-1:0] LAST_WORD = IW'(SECTOR_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_REQ, S_READ, S_WRITE, S_NEXT} state_t;

  state_t                state, state_n;
  logic [19:0]           lba_n, lba_inc, lba_seq;
  logic [IW-1:0]         word_idx, idx_n, idx_inc;
  logic                  pend_load, pend_n;
  logic                  rd_q, rd_n, wr_q, wr_n, playing_n, done_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n, lba_w, lba_off, sector_base;
  logic [15:0]           dout_q, dout_n;

  assign lba_w       = ADDR_WIDTH'(cur_lba);
  assign sector_base = base_addr + lba_off;
  assign lba_inc     = cur_lba + 20'd1;
  assign idx_inc     = word_idx + 1'b1;

  // 1176 = 1024 + 128 + 16 + 8, so the standard sector size needs no multiplier.
  generate
    if (SECTOR_WORDS == 1176) begin : g_shift_add
      assign lba_off = (lba_w << 10) + (lba_w << 7) + (lba_w << 4) + (lba_w << 3);
    end else begin : g_mul
      assign lba_off = lba_w * ADDR_WIDTH'(SECTOR_WORDS);
    end
  endgenerate

`ifdef CDDA_FEEDER_LOOP_EN
  assign lba_seq = (loop && lba_inc >= end_lba) ? start_lba : lba_inc;
`else
  logic loop_unused;
  assign loop_unused = loop;
  assign lba_seq     = lba_inc;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= S_IDLE;
      cur_lba   <= '0;
      word_idx  <= '0;
      pend_load <= 1'b0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      dout_q    <= '0;
      playing   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cur_lba   <= lba_n;
      word_idx  <= idx_n;
      pend_load <= pend_n;
      rd_q      <= rd_n;
      addr_q    <= addr_n;
      wr_q      <= wr_n;
      dout_q    <= dout_n;
      playing   <= playing_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    lba_n     = cur_lba;
    idx_n     = word_idx;
    pend_n    = pend_load;
    rd_n      = rd_q;
    addr_n    = addr_q;
    wr_n      = 1'b0;
    dout_n    = dout_q;
    playing_n = playing;
    done_n    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (load) lba_n = start_lba;
        if (play) state_n = S_WAIT_REQ;
      end
      // A seek here holds off the fetch one cycle so the whole sector uses the new base.
      S_WAIT_REQ: begin
        if (load) begin
          lba_n = start_lba;
        end else if (cur_lba >= end_lba) begin
          done_n    = 1'b1;
          playing_n = 1'b0;
          state_n   = S_IDLE;
        end else if (!play) begin
          playing_n = 1'b0;
          state_n   = S_IDLE;
        end else if (bus.hdd_cdda_req) begin
          idx_n     = '0;
          playing_n = 1'b1;
          rd_n      = 1'b1;
          addr_n    = sector_base;
          state_n   = S_READ;
        end
      end
      S_READ: begin
        if (load) pend_n = 1'b1;
        if (bus.mem_ack) begin
          rd_n    = 1'b0;
          wr_n    = 1'b1;
          dout_n  = bus.mem_data;
          state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        if (load) pend_n = 1'b1;
        if (word_idx == LAST_WORD) begin
          state_n = S_NEXT;
        end else begin
          idx_n   = idx_inc;
          rd_n    = 1'b1;
          addr_n  = sector_base + ADDR_WIDTH'(idx_inc);
          state_n = S_READ;
        end
      end
      S_NEXT: begin
        lba_n   = (load || pend_load) ? start_lba : lba_seq;
        pend_n  = 1'b0;
        state_n = S_WAIT_REQ;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.mem_rd       = rd_q;
  assign bus.mem_addr     = addr_q;
  assign bus.hdd_cdda_wr  = wr_q;
  assign bus.hdd_data_out = dout_q;
endmodule

// File: tb/tb_cdda_sector_feeder.sv
// Directed bench for cdda_sector_feeder: sector-level scoreboard of expected read addresses
// and write data, with a latency-programmable memory model.
module tb_cdda_sector_feeder;
  logic        clk_sys = 1'b0;
  logic        reset;
  logic [23:0] base_addr;
  logic [19:0] start_lba, end_lba, cur_lba;
  logic        load, play, loop, playing, done;

  cdda_sector_feeder_if #(.ADDR_WIDTH(24)) bus ();

  cdda_sector_feeder #(.ADDR_WIDTH(24), .SECTOR_WORDS(1176)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .base_addr (base_addr),
    .start_lba (start_lba),
    .end_lba   (end_lba),
    .load      (load),
    .play      (play),
    .loop      (loop),
    .bus       (bus),
    .playing   (playing),
    .done      (done),
    .cur_lba   (cur_lba)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] memf(input logic [23:0] a);
    return a[15:0] ^ {8'h00, a[23:16]} ^ 16'h5A3C;
  endfunction

  // Memory: acknowledges ack_lat cycles after the request first appears.
  int ack_lat = 1;
  int rd_cnt = 0;
  always @(posedge clk_sys) begin
    #1;
    if (bus.mem_rd) begin
      rd_cnt++;
      if (rd_cnt == ack_lat + 1) begin
        bus.mem_ack  = 1'b1;
        bus.mem_data = memf(bus.mem_addr);
      end else begin
        bus.mem_ack  = 1'b0;
        bus.mem_data = 16'hDEAD;
      end
    end else begin
      rd_cnt       = 0;
      bus.mem_ack  = 1'b0;
      bus.mem_data = 16'hDEAD;
    end
  end

  // Model: queue of word addresses the feeder must read, in order, one write per entry.
  logic [23:0] exp_q[$];

  task automatic push_sector(input int unsigned lba);
    for (int unsigned w = 0; w < 1176; w++)
      exp_q.push_back(24'(32'(base_addr) + lba * 1176 + w));
  endtask

  logic        prev_rd = 0, prev_ack = 0, prev_wr = 0;
  logic [23:0] prev_addr = '0, last_ack_addr = '0;
  logic [15:0] last_dout = '0;
  int          rd_len = 0, last_rd_len = 0, rd_starts = 0, wr_count = 0, done_count = 0;

  always @(negedge clk_sys) begin
    if (reset) begin
      prev_rd   = 0;
      prev_ack  = 0;
      prev_wr   = 0;
      rd_len    = 0;
      last_dout = '0;
    end else begin
      if (bus.mem_rd && !prev_rd) begin
        rd_starts++;
        chk("read_has_model_entry", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("rd_addr", bus.mem_addr, exp_q[0]);
      end
      if (prev_rd && !prev_ack) begin
        chk("rd_held", bus.mem_rd, 1);
        chk("addr_held", bus.mem_addr, prev_addr);
      end
      if (prev_rd && prev_ack) chk("rd_fall", bus.mem_rd, 0);
      if (bus.mem_rd) rd_len++;
      else if (prev_rd) begin
        last_rd_len = rd_len;
        rd_len      = 0;
      end
      if (bus.mem_rd && bus.mem_ack) last_ack_addr = bus.mem_addr;
      if (bus.hdd_cdda_wr) begin
        chk("wr_after_ack", 32'(prev_rd && prev_ack), 1);
        chk("wr_not_back_to_back", prev_wr, 0);
        chk("write_has_model_entry", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("wr_data", bus.hdd_data_out, memf(exp_q[0]));
          void'(exp_q.pop_front());
        end
        wr_count++;
        last_dout = bus.hdd_data_out;
      end else begin
        chk("dout_held", bus.hdd_data_out, last_dout);
      end
      if (done) done_count++;
      prev_rd   = bus.mem_rd;
      prev_ack  = bus.mem_ack;
      prev_wr   = bus.hdd_cdda_wr;
      prev_addr = bus.mem_addr;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic pulse_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (done) ok = 1;
    end
    chk(nm, ok, 1);
  endtask

  task automatic wait_wr(input string nm, input int target, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (wr_count >= target) ok = 1;
    end
    chk(nm, ok, 1);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (!playing) ok = 1;
    end
    chk(nm, ok, 1);
  endtask

  task automatic wait_rd(input string nm, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (bus.mem_rd) ok = 1;
    end
    chk(nm, ok, 1);
  endtask

  int w0, r0, d0;

  initial begin
    reset            = 1'b1;
    base_addr        = 24'h001000;
    start_lba        = '0;
    end_lba          = '0;
    load             = 1'b0;
    play             = 1'b0;
    loop             = 1'b0;
    bus.hdd_cdda_req = 1'b0;
    repeat (3) tick();
    chk("rst_mem_rd", bus.mem_rd, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_wr", bus.hdd_cdda_wr, 0);
    chk("rst_dout", bus.hdd_data_out, 0);
    chk("rst_playing", playing, 0);
    chk("rst_done", done, 0);
    chk("rst_cur_lba", cur_lba, 0);
    reset = 1'b0;
    tick();

    // Single sector LBA 2 with zero-wait memory.
    start_lba = 20'd2;
    end_lba   = 20'd3;
    bus.hdd_cdda_req = 1'b1;
    pulse_load();
    chk("t1_seek", cur_lba, 20'd2);
    w0 = wr_count;
    push_sector(2);
    play = 1'b1;
    wait_rd("t1_rd_timeout", 20);
    chk("t1_first_addr", bus.mem_addr, 24'h001930);
    wait_done("t1_done_timeout", 5000);
    play = 1'b0;
    chk("t1_playing_low", playing, 0);
    chk("t1_writes", wr_count - w0, 1176);
    chk("t1_last_addr", last_ack_addr, 24'h001DC7);
    chk("t1_cur_lba", cur_lba, 20'd3);
    chk("t1_model_drained", exp_q.size(), 0);
    tick();
    chk("t1_done_one_cycle", done, 0);

    // Five-cycle memory latency on LBA 3.
    ack_lat = 5;
    end_lba = 20'd4;
    w0 = wr_count;
    push_sector(3);
    play = 1'b1;
    wait_done("t2_done_timeout", 12000);
    play = 1'b0;
    chk("t2_writes", wr_count - w0, 1176);
    chk("t2_rd_hold_len", last_rd_len, 6);
    chk("t2_cur_lba", cur_lba, 20'd4);
    ack_lat = 1;

    // FIFO request low at sector boundaries, dropped mid-sector.
    end_lba = 20'd6;
    bus.hdd_cdda_req = 1'b0;
    w0 = wr_count;
    r0 = rd_starts;
    push_sector(4);
    push_sector(5);
    play = 1'b1;
    repeat (20) tick();
    chk("t3_no_read_without_req", rd_starts - r0, 0);
    chk("t3_not_playing", playing, 0);
    bus.hdd_cdda_req = 1'b1;
    wait_wr("t3_wr100_timeout", w0 + 100, 1000);
    bus.hdd_cdda_req = 1'b0;
    wait_wr("t3_sector_timeout", w0 + 1176, 5000);
    repeat (20) tick();
    chk("t3_reads_one_sector", rd_starts - r0, 1176);
    chk("t3_cur_lba", cur_lba, 20'd5);
    bus.hdd_cdda_req = 1'b1;
    wait_done("t3_done_timeout", 5000);
    play = 1'b0;
    chk("t3_writes", wr_count - w0, 2352);

    // Pause at word 100 of LBA 5, then resume at LBA 6.
    start_lba = 20'd5;
    end_lba   = 20'd8;
    pulse_load();
    chk("t4_seek", cur_lba, 20'd5);
    w0 = wr_count;
    push_sector(5);
    play = 1'b1;
    wait_wr("t4_wr100_timeout", w0 + 100, 1000);
    play = 1'b0;
    wait_idle("t4_idle_timeout", 5000);
    chk("t4_writes", wr_count - w0, 1176);
    chk("t4_cur_lba", cur_lba, 20'd6);
    chk("t4_model_drained", exp_q.size(), 0);
    end_lba = 20'd7;
    push_sector(6);
    play = 1'b1;
    wait_rd("t4_resume_timeout", 20);
    chk("t4_resume_addr", bus.mem_addr, 24'h002B90);
    wait_done("t4_done_timeout", 5000);
    play = 1'b0;
    chk("t4_end_lba", cur_lba, 20'd7);

    // Seek to LBA 0 requested at word 500 of LBA 7.
    end_lba = 20'd9;
    w0 = wr_count;
    push_sector(7);
    play = 1'b1;
    wait_wr("t5_wr500_timeout", w0 + 500, 3000);
    start_lba = 20'd0;
    pulse_load();
    push_sector(0);
    wait_wr("t5_lba0_timeout", w0 + 1177, 5000);
    play = 1'b0;
    wait_idle("t5_idle_timeout", 5000);
    chk("t5_writes", wr_count - w0, 2352);
    chk("t5_cur_lba", cur_lba, 20'd1);
    chk("t5_model_drained", exp_q.size(), 0);

    // Loop between LBA 4 and 6.
    start_lba = 20'd4;
    end_lba   = 20'd6;
    loop      = 1'b1;
    pulse_load();
    chk("t6_seek", cur_lba, 20'd4);
    w0 = wr_count;
    d0 = done_count;
`ifdef CDDA_FEEDER_LOOP_EN
    push_sector(4);
    push_sector(5);
    push_sector(4);
    push_sector(5);
    play = 1'b1;
    wait_wr("t6_loop_timeout", w0 + 4704, 16000);
    play = 1'b0;
    wait_idle("t6_idle_timeout", 100);
    chk("t6_no_done", done_count - d0, 0);
    chk("t6_cur_lba", cur_lba, 20'd4);
`else
    push_sector(4);
    push_sector(5);
    play = 1'b1;
    wait_done("t6_done_timeout", 8000);
    play = 1'b0;
    chk("t6_writes", wr_count - w0, 2352);
    chk("t6_cur_lba", cur_lba, 20'd6);
`endif
    chk("t6_model_drained", exp_q.size(), 0);
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cdda_sector_feeder.md
# cdda_sector_feeder

Source side of the CD-audio path: streams 2352-byte raw CDDA sectors from a word-addressed memory (SDRAM-hosted CD image) into `cdda_fifo` through the `hdd_cdda_req` / `hdd_cdda_wr` / `hdd_data_out` handshake. Sits between the SDRAM arbiter and `cdda_fifo` when the image is local rather than pushed over SPI by the ARM controller. It tracks the current LBA, supports play/pause and seek, and always writes whole sectors so the FIFO's left/right word alignment is never broken.

## Interface
- `ADDR_WIDTH`, 24, memory word-address width.
- `SECTOR_WORDS`, 1176, 16-bit words per sector (2352 bytes); must be even.

- `clk_sys` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `base_addr` in ADDR_WIDTH: word address of LBA 0 in the image.
- `start_lba` in 20: seek target.
- `end_lba` in 20: exclusive stop LBA.
- `load` in 1: one-cycle pulse, seek to `start_lba`.
- `play` in 1: level, 1 = stream.
- `loop` in 1: wrap to `start_lba` at `end_lba` (only with macro).
- `mem_rd` out 1: read request, held until `mem_ack`.
- `mem_addr` out ADDR_WIDTH: read word address.
- `mem_ack` in 1: `mem_data` valid this cycle.
- `mem_data` in 16: read data.
- `hdd_cdda_req` in 1: FIFO has room for one full sector.
- `hdd_cdda_wr` out 1: one-cycle write strobe.
- `hdd_data_out` out 16: write data, memory word passed through unmodified (FIFO does the byte swap).
- `playing` out 1: high from sector fetch start until stop.
- `done` out 1: one-cycle pulse on reaching `end_lba` without loop.
- `cur_lba` out 20: LBA being (or next to be) streamed.

## Operation
- States: IDLE, WAIT_REQ, READ, WRITE, NEXT.
- IDLE: if `play`=1 → WAIT_REQ.
- WAIT_REQ: if `cur_lba >= end_lba` → `done` pulse, `playing`=0, IDLE. Else if `play`=0 → IDLE. Else if `hdd_cdda_req`=1 → READ with `word_idx`=0, `playing`=1.
- READ: `mem_rd`=1, `mem_addr` = `sector_base + word_idx`. On `mem_ack`: capture `mem_data`, → WRITE.
- WRITE: `hdd_cdda_wr`=1 for exactly this cycle. If `word_idx == SECTOR_WORDS-1` → NEXT, else `word_idx+1`, → READ.
- NEXT: `cur_lba+1`; if result ≥ `end_lba` and loop enabled and `loop`=1, `cur_lba` ← `start_lba`. → WAIT_REQ (end check happens there).
- `sector_base` = `base_addr + cur_lba*1176` (shift-add: <<10 + <<7 + <<4 + <<3), recomputed whenever `cur_lba` changes; truncated mod 2^ADDR_WIDTH, wrap permitted.
- `load`: in IDLE/WAIT_REQ, `cur_lba` ← `start_lba` next cycle. In READ/WRITE/NEXT, latched as pending and applied at NEXT instead of increment/wrap. `load` and NEXT in the same cycle: load wins.
- `play` dropping mid-sector: sector completes, then WAIT_REQ → IDLE with `cur_lba` pointing at the next sector (pause/resume seamless).
- `hdd_cdda_req` only sampled in WAIT_REQ; dropping mid-sector is ignored (FIFO guaranteed sector room at start).

## Timing
- Reset values: `mem_rd`=0, `mem_addr`=0, `hdd_cdda_wr`=0, `hdd_data_out`=0, `playing`=0, `done`=0, `cur_lba`=0, state IDLE, pending load cleared.
- All outputs registered. `mem_rd` rises the first cycle in READ; falls the cycle after `mem_ack`.
- `hdd_cdda_wr` asserted the cycle after `mem_ack`, `hdd_data_out` = acked word that same cycle and held until next write.
- Zero-wait memory: 3 cycles per word (READ, ack, WRITE), plus 1 cycle NEXT and ≥1 cycle WAIT_REQ per sector.
- `hdd_cdda_wr` never asserted twice in consecutive cycles; FIFO `clk_en` must be tied 1.
- Reset mid-read drops `mem_rd` immediately; memory controller must tolerate an abandoned request.

## Configuration
- `CDDA_FEEDER_LOOP_EN` defined: `loop` honoured, wrap to `start_lba` in NEXT, `done` not pulsed while looping.
- Undefined: `loop` ignored; reaching `end_lba` always pulses `done` and stops.

## Test plan
- Reset, `base_addr`=0x1000, `start_lba`=2, `load`, `play`=1, `end_lba`=3, `hdd_cdda_req`=1, zero-wait memory → first `mem_addr`=0x1930, exactly 1176 writes, last addr 0x1DC7, then `done` pulse, `playing`=0.
- Memory ack delayed 5 cycles → `mem_rd` held 6 cycles, write data equals acked word, write count unchanged.
- `hdd_cdda_req`=0 at sector boundary → no `mem_rd` until req rises; mid-sector drop of req → sector still completes.
- `play` dropped at word 100 of LBA 5 → 1176 writes total for LBA 5, IDLE, `cur_lba`=6; `play`=1 resumes at LBA 6 address.
- `load` with `start_lba`=0 at word 500 of LBA 7 → LBA 7 finishes, next sector fetched is LBA 0.
- With `CDDA_FEEDER_LOOP_EN`, `start_lba`=4, `end_lba`=6, `loop`=1 → sector sequence 4,5,4,5, no `done`; without macro → 4,5, `done`.
